// File: rtl/bus_arbiter.sv
// Round-robin data-bus arbiter: grants one of NUM_MST masters with a bounded hold
// time and muxes the owner's address, write data and strobes onto the slave bus.
module bus_arbiter #(
  parameter int NUM_MST  = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MST-1:0]     mst_req,
  output logic [NUM_MST-1:0]     mst_grant,
  input  logic [NUM_MST-1:0]     mst_wr,
  input  logic [NUM_MST-1:0]     mst_rd,
  input  logic [8*NUM_MST-1:0]   mst_addr,
  input  logic [8*NUM_MST-1:0]   mst_wr_data,
  output logic [7:0]             mst_rd_data,
  output logic                   slv_wr,
  output logic                   slv_rd,
  output logic [7:0]             slv_addr,
  output logic [7:0]             slv_wr_data,
  input  logic [7:0]             slv_rd_data,
  output logic [1:0]             owner_id,
  output logic                   busy
);

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
  localparam logic [1:0] LAST_RST  = 2'(NUM_MST - 1);

  logic       busy_q, busy_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [3:0] hold_q, hold_d;

  logic       owner_req, owner_wr, owner_rd;
  logic [7:0] owner_addr, owner_wdata;
  logic [2:0] pick_all, pick_oth;

  // Returns {found, index}; scanning starts after `last` so the previous winner is seen last.
  function automatic logic [2:0] rr_pick(input logic [NUM_MST-1:0] req,
                                         input logic [1:0]         last,
                                         input logic               excl_en,
                                         input logic [1:0]         excl);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 1; k <= NUM_MST; k++) begin
      cand = 2'((int'(last) + k) % NUM_MST);
      for (int i = 0; i < NUM_MST; i++) begin
        if (!found && (2'(i) == cand) && req[i] && !(excl_en && (2'(i) == excl))) begin
          found = 1'b1;
          idx   = 2'(i);
        end
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    owner_req   = 1'b0;
    owner_wr    = 1'b0;
    owner_rd    = 1'b0;
    owner_addr  = 8'h00;
    owner_wdata = 8'h00;
    mst_grant   = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (owner_q == 2'(i)) begin
        owner_req   = mst_req[i];
        owner_wr    = mst_wr[i];
        owner_rd    = mst_rd[i];
        owner_addr  = mst_addr[8*i +: 8];
        owner_wdata = mst_wr_data[8*i +: 8];
      end
      mst_grant[i] = busy_q && (owner_q == 2'(i)) && mst_req[i];
    end
  end

  assign slv_wr      = busy_q & owner_req & owner_wr;
  assign slv_rd      = busy_q & owner_req & owner_rd;
  assign slv_addr    = busy_q ? owner_addr  : 8'h00;
  assign slv_wr_data = busy_q ? owner_wdata : 8'h00;
  assign mst_rd_data = slv_rd_data;
  assign owner_id    = owner_q;
  assign busy        = busy_q;

  always_comb begin
    busy_d   = busy_q;
    owner_d  = owner_q;
    last_d   = last_q;
    hold_d   = hold_q;
    pick_all = rr_pick(mst_req, last_q, 1'b0, 2'd0);
    pick_oth = rr_pick(mst_req, last_q, 1'b1, owner_q);
    if (!busy_q) begin
      if (pick_all[2]) begin
        busy_d  = 1'b1;
        owner_d = pick_all[1:0];
        last_d  = pick_all[1:0];
        hold_d  = 4'd0;
      end
    end else if (!owner_req) begin
      // Owner released: hand straight to the next requester, or go idle.
      if (pick_all[2]) begin
        owner_d = pick_all[1:0];
        last_d  = pick_all[1:0];
        hold_d  = 4'd0;
      end else begin
        busy_d = 1'b0;
      end
    end else if ((hold_q == HOLD_LAST) && pick_oth[2]) begin
      owner_d = pick_oth[1:0];
      last_d  = pick_oth[1:0];
      hold_d  = 4'd0;
    end else if (hold_q != HOLD_LAST) begin
      hold_d = hold_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      owner_q <= 2'd0;
      last_q  <= LAST_RST;
      hold_q  <= 4'd0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a 2-master instance for handshake, handoff,
// preemption and reset cases, and a 4-master instance for full rotation.
module tb_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0]  req2, wr2, rd2, grant2, owner2;
  logic [15:0] addr2, wdata2;
  logic [7:0]  mrd2, saddr2, swdata2, srd2;
  logic        swr2, srd_en2, busy2;

  logic [3:0]  req4, wr4, rd4, grant4;
  logic [31:0] addr4, wdata4;
  logic [7:0]  mrd4, saddr4, swdata4, srd4;
  logic        swr4, srd_en4, busy4;
  logic [1:0]  owner4;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter #(.NUM_MST(2), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .mst_req(req2), .mst_grant(grant2), .mst_wr(wr2), .mst_rd(rd2),
    .mst_addr(addr2), .mst_wr_data(wdata2), .mst_rd_data(mrd2), .slv_wr(swr2), .slv_rd(srd_en2),
    .slv_addr(saddr2), .slv_wr_data(swdata2), .slv_rd_data(srd2), .owner_id(owner2), .busy(busy2)
  );

  bus_arbiter #(.NUM_MST(4), .MAX_HOLD(8)) dut4 (
    .clk(clk), .rst(rst), .mst_req(req4), .mst_grant(grant4), .mst_wr(wr4), .mst_rd(rd4),
    .mst_addr(addr4), .mst_wr_data(wdata4), .mst_rd_data(mrd4), .slv_wr(swr4), .slv_rd(srd_en4),
    .slv_addr(saddr4), .slv_wr_data(swdata4), .slv_rd_data(srd4), .owner_id(owner4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    int ord[5];
    logic [3:0] eg;
    ord = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req2 = '0; wr2 = '0; rd2 = '0; addr2 = '0; wdata2 = '0; srd2 = '0;
    req4 = '0; wr4 = '0; rd4 = '0; addr4 = '0; wdata4 = '0; srd4 = '0;
    step();
    step();
    chk("rst_grant", grant2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_owner", owner2, 0);
    chk("rst_slv_wr", swr2, 0);
    chk("rst_slv_rd", srd_en2, 0);
    chk("rst_slv_addr", saddr2, 0);
    chk("rst_slv_wdata", swdata2, 0);
    chk("rst_grant4", grant4, 0);

    // Test 1: CPU read
    rst = 1'b0;
    req2 = 2'b01; rd2 = 2'b01; addr2 = 16'h003C; srd2 = 8'hA5;
    settle();
    chk("t1_req_cycle_grant", grant2, 0);
    chk("t1_req_cycle_busy", busy2, 0);
    chk("t1_rd_data_bcast", mrd2, 8'hA5);
    step();
    chk("t1_grant", grant2, 2'b01);
    chk("t1_slv_rd", srd_en2, 1);
    chk("t1_slv_addr", saddr2, 8'h3C);
    chk("t1_rd_data", mrd2, 8'hA5);
    step();
    req2 = 2'b00; rd2 = 2'b00;
    settle();
    chk("t1_dead_grant", grant2, 0);
    chk("t1_dead_busy", busy2, 1);
    chk("t1_dead_slv_rd", srd_en2, 0);
    step();
    chk("t1_idle_busy", busy2, 0);

    // Test 2: simultaneous requests, zero-gap handoff
    rst = 1'b1;
    step();
    rst = 1'b0;
    req2 = 2'b11;
    step();
    chk("t2_first_grant", grant2, 2'b01);
    chk("t2_first_owner", owner2, 0);
    req2 = 2'b10;
    settle();
    chk("t2_drop_grant", grant2, 2'b00);
    step();
    chk("t2_handoff_grant", grant2, 2'b10);
    chk("t2_handoff_owner", owner2, 1);

    // Test 3: DMA burst preempted after MAX_HOLD cycles
    rst = 1'b1;
    step();
    rst = 1'b0;
    req2 = 2'b10;
    step();
    for (int g = 1; g <= 8; g++) begin
      chk($sformatf("t3_m1_cycle%0d", g), grant2, 2'b10);
      if (g == 3) req2 = 2'b11;
      step();
    end
    chk("t3_preempt_grant", grant2, 2'b01);
    chk("t3_preempt_owner", owner2, 0);
    req2 = 2'b10;
    settle();
    chk("t3_dead_grant", grant2, 2'b00);
    step();
    chk("t3_regrant", grant2, 2'b10);

    // Test 4: four masters in rotation
    rst = 1'b1;
    step();
    rst = 1'b0;
    req2 = 2'b00;
    req4 = 4'b1111;
    step();
    for (int n = 0; n < 5; n++) begin
      eg = 4'b0001 << ord[n];
      for (int c = 0; c < 8; c++) begin
        chk($sformatf("t4_grant_o%0d_c%0d", n, c), grant4, eg);
        chk($sformatf("t4_owner_o%0d_c%0d", n, c), owner4, ord[n]);
        step();
      end
    end
    req4 = 4'b0000;

    // Test 5: reset during a write
    rst = 1'b1;
    step();
    rst = 1'b0;
    req2 = 2'b10; wr2 = 2'b10; addr2 = 16'h8000; wdata2 = 16'h5A00;
    step();
    chk("t5_grant", grant2, 2'b10);
    chk("t5_slv_wr", swr2, 1);
    chk("t5_slv_addr", saddr2, 8'h80);
    chk("t5_slv_wdata", swdata2, 8'h5A);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    chk("t5_rst_slv_wr", swr2, 0);
    chk("t5_rst_grant", grant2, 0);
    chk("t5_rst_busy", busy2, 0);
    chk("t5_rst_slv_addr", saddr2, 0);
    req2 = 2'b11; addr2 = 16'h8011; wr2 = 2'b10;
    step();
    chk("t5_after_rst_grant", grant2, 2'b01);
    chk("t5_after_rst_owner", owner2, 0);

    // Test 6: non-owner strobes ignored
    chk("t6_slv_wr_c0", swr2, 0);
    chk("t6_slv_addr_c0", saddr2, 8'h11);
    step();
    chk("t6_slv_wr_c1", swr2, 0);
    chk("t6_slv_addr_c1", saddr2, 8'h11);
    req2 = 2'b10;
    settle();
    chk("t6_drop_slv_wr", swr2, 0);
    chk("t6_drop_slv_addr", saddr2, 8'h11);
    step();
    chk("t6_m1_grant", grant2, 2'b10);
    chk("t6_m1_slv_wr", swr2, 1);
    chk("t6_m1_slv_addr", saddr2, 8'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Target side of the data-bus request/grant handshake that the CPU controller initiates.
- Arbitrates NUM_MST bus masters (CPU, debug, DMA) onto the single data-memory/peripheral bus.
- Grants use round-robin priority with a bounded hold time.
- Muxes the owner's address, write data and strobes to the slave side; read data is broadcast to all masters.

Parameters:
- NUM_MST, 2, number of masters (2..4); master 0 is the CPU.
- MAX_HOLD, 8, granted cycles after which an owner is preempted if another master requests (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mst_req  in  NUM_MST  bus request per master
- mst_grant  out  NUM_MST  bus grant per master; the transfer completes in every cycle grant is high
- mst_wr  in  NUM_MST  write strobe per master
- mst_rd  in  NUM_MST  read strobe per master
- mst_addr  in  8*NUM_MST  address, master i at bits [8i+7:8i]
- mst_wr_data  in  8*NUM_MST  write data, same packing
- mst_rd_data  out  8  slv_rd_data broadcast to all masters
- slv_wr  out  1  slave write enable
- slv_rd  out  1  slave read enable
- slv_addr  out  8  slave address
- slv_wr_data  out  8  slave write data
- slv_rd_data  in  8  slave read data; combinational, valid in the slv_rd cycle
- owner_id  out  2  current owner index (debug/status)
- busy  out  1  bus owned

Behaviour:
- Registered state: busy, owner[1:0], last[1:0], hold_cnt[3:0].
- Reset (synchronous, overrides everything): busy=0, owner=0, last=NUM_MST-1, hold_cnt=0.
  - Consequence: all grants, slv_wr and slv_rd are 0; slv_addr and slv_wr_data are 0; owner_id=0.
- Combinational outputs:
  - mst_grant[i] = busy & (owner==i) & mst_req[i].
  - slv_wr = busy & mst_req[owner] & mst_wr[owner]; slv_rd likewise with mst_rd.
  - slv_addr and slv_wr_data = the owner's fields when busy, else 8'h00.
  - mst_rd_data = slv_rd_data, unconditionally.
- Round-robin pick: the first requester scanning (last+1), (last+2), ... mod NUM_MST. A master's own request is scanned last.
- IDLE (busy=0): at an edge with any mst_req high, set busy=1, owner=pick, last=pick, hold_cnt=0.
  - The grant is visible the cycle after the request is first seen: 1-cycle latency.
- BUSY, evaluated at each edge:
  - Release: if mst_req[owner]=0, re-arbitrate over current requests.
    - Pick found: owner=pick, last=pick, hold_cnt=0, busy stays 1. This is a zero-gap handoff.
    - No requests: busy=0.
  - Preempt: else if hold_cnt==MAX_HOLD-1 and any other master requests, owner=pick excluding the current owner, hold_cnt=0. The preempted master's grant drops and it keeps waiting.
  - Otherwise: hold_cnt increments, saturating at MAX_HOLD-1.
- The CPU drops its request the cycle after it sees a grant. Its ownership therefore ends one cycle later, and that trailing cycle has grant=0 and no strobes. This dead cycle is accepted.
- A master that drops its request and re-raises it with no competitors is regranted after 1 idle cycle.
- Simultaneous requests from all masters are served in strict rotation; each master waits at most (NUM_MST-1)*MAX_HOLD+1 cycles.
- mst_wr and mst_rd both high for the owner: both slave strobes are passed through and the slave defines the result. This is not checked.
- Strobes from non-owners are ignored.
- Reset asserted during a transfer: grants and strobes are 0 in the cycle after the reset edge. No partial state is retained.
- owner_id is the owner register zero-extended to 2 bits; busy is the busy register.

Test Plan:
1. Reset, then CPU (master 0) asserts req with rd, addr 8'h3C, and slv_rd_data=8'hA5.
   - No grant in the request cycle.
   - Next cycle: mst_grant=01, slv_rd=1, slv_addr=8'h3C, mst_rd_data=8'hA5.
   - busy falls 2 cycles after the CPU drops req.
2. Master 0 and master 1 raise req in the same cycle from reset.
   - Master 0 is granted first.
   - When master 0 drops req, master 1 is granted on the next cycle with no gap.
3. Master 1 holds req continuously (DMA burst) with MAX_HOLD=8; master 0 raises req at grant cycle 3.
   - Master 1 is granted for exactly 8 cycles, then master 0 for 1 cycle.
   - Master 1 is then regranted.
4. With NUM_MST=4, all masters request continuously.
   - Grant order is 0,1,2,3,0; each owner holds for 8 cycles.
   - owner_id tracks the order.
5. Master 1 granted with wr=1, addr 8'h80, wr_data 8'h5A; rst pulsed for one cycle mid-grant.
   - Cycle after the reset edge: slv_wr=0, mst_grant=0, busy=0.
   - The first request after reset is arbitrated starting at master 0.
6. Master 1 requests with wr=1 while master 0 owns the bus.
   - slv_wr stays 0 and slv_addr shows master 0's address until master 1 is granted.
